// File: rtl/pulse_timing_gen.sv
// pulse_timing_gen
//   Generates one switching period of Ts clocks made of up to four phases:
//   ON (main switch), DEAD (all off), NEG (negative-pulse switch) and OFF
//   (optional bypass switch). All timing parameters are captured into
//   shadow registers when the generator starts and at each period boundary,
//   so changes made in the middle of a period wait for the next one.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   power_Start              run enable; low forces IDLE on the next edge
//   Start1..Start4           cut-mode select, must be one-hot
//   panglu_en, Vneg_en       bypass enable in OFF, negative-pulse enable
//   Ton, Ts, Dt              on-time, period, dead-time (clk counts)
//   T_neg                    negative-pulse width (clk counts)
//   gate_main/neg/bypass     registered switch drives
//   running                  generator is not IDLE
//   period_tick              high on the last cycle of every period
//   fault                    sticky: invalid parameters seen at a boundary
//   dbg_state                current FSM state (IDLE/ON/DEAD/NEG/OFF)
//
// Timing: when valid parameters are sampled on edge k the FSM leaves IDLE
// into a one-cycle arming slot (running=1, gates 0, cnt held at 0); the
// first real period cycle (cnt=0) is the cycle after edge k+1. All outputs
// are registered from the next-state values, so they line up with state/cnt.
module pulse_timing_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_Start,
  input  logic             Start1,
  input  logic             Start2,
  input  logic             Start3,
  input  logic             Start4,
  input  logic             panglu_en,
  input  logic             Vneg_en,
  input  logic [CNT_W-1:0] Ton,
  input  logic [CNT_W-1:0] Ts,
  input  logic [CNT_W-1:0] Dt,
  input  logic [7:0]       T_neg,
  output logic             gate_main,
  output logic             gate_neg,
  output logic             gate_bypass,
  output logic             running,
  output logic             period_tick,
  output logic             fault,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ON   = 3'd1;
  localparam logic [2:0] S_DEAD = 3'd2;
  localparam logic [2:0] S_NEG  = 3'd3;
  localparam logic [2:0] S_OFF  = 3'd4;

  // State and shadow registers
  logic [2:0]       state, state_n;
  logic             arm, arm_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] ph, ph_n;          // cycles spent in the current phase
  logic [CNT_W-1:0] ton_l, ton_n;
  logic [CNT_W-1:0] ts_l, ts_n;
  logic [CNT_W-1:0] dt_l, dt_n;
  logic [7:0]       tneg_l, tneg_n;
  logic             panglu_l, panglu_n;
  logic             vneg_l, vneg_n;
  logic [3:0]       mode_l, mode_n;
  logic             fault_n;

  // Derived values
  logic [3:0]       mode_in;
  logic             in_valid;
  logic             neg_on;
  logic             in_neg_on;
  logic [CNT_W-1:0] ts_last;
  logic [CNT_W-1:0] dead_last;
  logic [CNT_W-1:0] tneg_last;

  assign mode_in   = {Start4, Start3, Start2, Start1};
  assign in_valid  = power_Start && $onehot(mode_in) &&
                     (Ts >= CNT_W'(2)) && (Ton < Ts);
  assign neg_on    = vneg_l && (tneg_l != 8'd0);
  assign in_neg_on = Vneg_en && (T_neg != 8'd0);
  assign ts_last   = ts_l - 1'b1;
  // DEAD is entered with dt_l==0 only to separate ON from NEG; it then
  // lasts a single cycle so the two switches are never adjacent.
  assign dead_last = (dt_l == '0) ? '0 : dt_l - 1'b1;
  assign tneg_last = CNT_W'(tneg_l) - 1'b1;
  assign dbg_state = state;

  // First phase of a period given the (new) shadow values.
  function automatic logic [2:0] first_phase(input logic [CNT_W-1:0] ton,
                                             input logic [CNT_W-1:0] dt,
                                             input logic             neg);
    if (ton != '0)      first_phase = S_ON;
    else if (dt != '0)  first_phase = S_DEAD;
    else if (neg)       first_phase = S_NEG;
    else                first_phase = S_OFF;
  endfunction

  always_comb begin
    state_n  = state;
    arm_n    = arm;
    cnt_n    = cnt;
    ph_n     = ph;
    ton_n    = ton_l;
    ts_n     = ts_l;
    dt_n     = dt_l;
    tneg_n   = tneg_l;
    panglu_n = panglu_l;
    vneg_n   = vneg_l;
    mode_n   = mode_l;
    fault_n  = fault;

    if (!power_Start) begin
      // Run enable dropped: stop immediately, no fault.
      state_n = S_IDLE;
      arm_n   = 1'b0;
      cnt_n   = '0;
      ph_n    = '0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        ton_n    = Ton;
        ts_n     = Ts;
        dt_n     = Dt;
        tneg_n   = T_neg;
        panglu_n = panglu_en;
        vneg_n   = Vneg_en;
        mode_n   = mode_in;
        state_n  = S_ON;
        arm_n    = 1'b1;
        cnt_n    = '0;
        ph_n     = '0;
        fault_n  = 1'b0;
      end
    end else if (arm) begin
      // Arming slot: cnt stays 0 so the first real cycle is cnt=0.
      arm_n   = 1'b0;
      cnt_n   = '0;
      ph_n    = '0;
      state_n = first_phase(ton_l, dt_l, neg_on);
    end else if (cnt == ts_last) begin
      // Period boundary overrides whatever phase is active.
      ton_n    = Ton;
      ts_n     = Ts;
      dt_n     = Dt;
      tneg_n   = T_neg;
      panglu_n = panglu_en;
      vneg_n   = Vneg_en;
      mode_n   = mode_in;
      cnt_n    = '0;
      ph_n     = '0;
      if (in_valid) begin
        state_n = first_phase(Ton, Dt, in_neg_on);
      end else begin
        state_n = S_IDLE;
        fault_n = 1'b1;
      end
    end else begin
      cnt_n = cnt + 1'b1;
      ph_n  = ph + 1'b1;
      case (state)
        S_ON: begin
          if (ph == ton_l - 1'b1) begin
            ph_n    = '0;
            state_n = ((dt_l != '0) || neg_on) ? S_DEAD : S_OFF;
          end
        end
        S_DEAD: begin
          if (ph == dead_last) begin
            ph_n    = '0;
            state_n = neg_on ? S_NEG : S_OFF;
          end
        end
        S_NEG: begin
          if (ph == tneg_last) begin
            ph_n    = '0;
            state_n = S_OFF;
          end
        end
        default: ph_n = ph;  // OFF holds until the boundary
      endcase
      // The last cycle of a period is never NEG, so a following ON phase
      // always sees at least one cycle with both switches low.
      if ((state_n == S_NEG) && (cnt_n == ts_last)) state_n = S_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      arm         <= 1'b0;
      cnt         <= '0;
      ph          <= '0;
      ton_l       <= '0;
      ts_l        <= '0;
      dt_l        <= '0;
      tneg_l      <= '0;
      panglu_l    <= 1'b0;
      vneg_l      <= 1'b0;
      mode_l      <= '0;
      fault       <= 1'b0;
      gate_main   <= 1'b0;
      gate_neg    <= 1'b0;
      gate_bypass <= 1'b0;
      running     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_n;
      arm         <= arm_n;
      cnt         <= cnt_n;
      ph          <= ph_n;
      ton_l       <= ton_n;
      ts_l        <= ts_n;
      dt_l        <= dt_n;
      tneg_l      <= tneg_n;
      panglu_l    <= panglu_n;
      vneg_l      <= vneg_n;
      mode_l      <= mode_n;
      fault       <= fault_n;
      // Drives are qualified by a one-hot mode so a corrupted shadow can
      // never turn a switch on.
      gate_main   <= (state_n == S_ON) && !arm_n && $onehot(mode_n);
      gate_neg    <= (state_n == S_NEG) && $onehot(mode_n);
      gate_bypass <= (state_n == S_OFF) && panglu_n && $onehot(mode_n);
      running     <= (state_n != S_IDLE);
      period_tick <= (state_n != S_IDLE) && !arm_n && (cnt_n == ts_n - 1'b1);
    end
  end

endmodule

// File: tb/tb_pulse_timing_gen.sv
module tb_pulse_timing_gen;

  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic             rst;
  logic             power_Start;
  logic             Start1, Start2, Start3, Start4;
  logic             panglu_en, Vneg_en;
  logic [CNT_W-1:0] Ton, Ts, Dt;
  logic [7:0]       T_neg;
  logic             gate_main, gate_neg, gate_bypass;
  logic             running, period_tick, fault;
  logic [2:0]       dbg_state;

  pulse_timing_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .power_Start(power_Start),
    .Start1(Start1), .Start2(Start2), .Start3(Start3), .Start4(Start4),
    .panglu_en(panglu_en), .Vneg_en(Vneg_en),
    .Ton(Ton), .Ts(Ts), .Dt(Dt), .T_neg(T_neg),
    .gate_main(gate_main), .gate_neg(gate_neg), .gate_bypass(gate_bypass),
    .running(running), .period_tick(period_tick), .fault(fault),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic prev_main = 1'b0;
  logic prev_neg  = 1'b0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    power_Start = 1'b0;
    step(2);
    rst = 1'b0;
    prev_main = 1'b0;
    prev_neg  = 1'b0;
  endtask

  task automatic set_cfg(input int mode, input int ton, input int ts,
                         input int dt, input int tneg, input logic vneg,
                         input logic pang);
    Start1 = (mode == 1); Start2 = (mode == 2);
    Start3 = (mode == 3); Start4 = (mode == 4);
    Ton = CNT_W'(ton); Ts = CNT_W'(ts); Dt = CNT_W'(dt);
    T_neg = 8'(tneg); Vneg_en = vneg; panglu_en = pang;
  endtask

  // Power up and advance to the cycle with cnt=0 (two edges later).
  task automatic start_run(input string tag);
    power_Start = 1'b1;
    step();
    chk({tag, "_arm_main"}, gate_main, 0);
    chk({tag, "_arm_running"}, running, 1);
    step();
  endtask

  // Starting in a cnt=0 cycle, sample until period_tick (inclusive) and
  // return per-gate cycle counts. Optionally changes Ton/Ts at cycle chg_at.
  task automatic measure(input int max_cyc, input int chg_at,
                         input int new_ton, input int new_ts,
                         output int len, output int n_main, output int n_neg,
                         output int n_byp, output int n_none,
                         output int n_bad);
    len = 0; n_main = 0; n_neg = 0; n_byp = 0; n_none = 0; n_bad = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i == chg_at) begin
        Ton = CNT_W'(new_ton);
        Ts  = CNT_W'(new_ts);
      end
      if (gate_main) n_main++;
      if (gate_neg) n_neg++;
      if (gate_bypass) n_byp++;
      if (!gate_main && !gate_neg && !gate_bypass) n_none++;
      if ((gate_main && gate_neg) || (gate_main && prev_neg) ||
          (gate_neg && prev_main)) n_bad++;
      prev_main = gate_main;
      prev_neg  = gate_neg;
      if (period_tick) begin
        len = i + 1;
        step();
        return;
      end
      step();
    end
  endtask

  int len, nm, nn, nb, nz, nx;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    power_Start = 1'b0;
    set_cfg(1, 0, 0, 0, 0, 1'b0, 1'b0);
    step(3);

    // Reset values with reset held
    chk("rst_main", gate_main, 0);
    chk("rst_neg", gate_neg, 0);
    chk("rst_byp", gate_bypass, 0);
    chk("rst_running", running, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_fault", fault, 0);

    // Mode1, Ton change 2500->1000 (and Ts->3000) at cnt=100
    do_reset();
    set_cfg(1, 2500, 22500, 46, 0, 1'b0, 1'b0);
    start_run("m1");
    chk("m1_first_main", gate_main, 1);
    measure(23000, 100, 1000, 3000, len, nm, nn, nb, nz, nx);
    chk("m1_len", len, 22500);
    chk("m1_main", nm, 2500);
    chk("m1_neg", nn, 0);
    chk("m1_byp", nb, 0);
    measure(23000, -1, 0, 0, len, nm, nn, nb, nz, nx);
    chk("m1_p2_len", len, 3000);
    chk("m1_p2_main", nm, 1000);

    // Mode3: 50 main, 2 dead, 100 neg, 598 bypass
    do_reset();
    set_cfg(3, 50, 750, 2, 100, 1'b1, 1'b1);
    start_run("m3");
    for (int p = 0; p < 2; p++) begin
      measure(1000, -1, 0, 0, len, nm, nn, nb, nz, nx);
      chk("m3_len", len, 750);
      chk("m3_main", nm, 50);
      chk("m3_neg", nn, 100);
      chk("m3_byp", nb, 598);
      chk("m3_dead", nz, 2);
      chk("m3_overlap", nx, 0);
    end

    // Mode2: Ton=0, bypass through the whole period
    do_reset();
    set_cfg(2, 0, 3000, 0, 0, 1'b0, 1'b1);
    start_run("m2");
    measure(3500, -1, 0, 0, len, nm, nn, nb, nz, nx);
    chk("m2_len", len, 3000);
    chk("m2_main", nm, 0);
    chk("m2_byp", nb, 3000);

    // Dt=0 with negative pulse: one forced gap cycle between ON and NEG
    do_reset();
    set_cfg(4, 10, 40, 0, 5, 1'b1, 1'b0);
    start_run("gap");
    measure(100, -1, 0, 0, len, nm, nn, nb, nz, nx);
    chk("gap_len", len, 40);
    chk("gap_main", nm, 10);
    chk("gap_neg", nn, 5);
    chk("gap_none", nz, 25);
    chk("gap_overlap", nx, 0);

    // Truncation: Ton+Dt+T_neg >= Ts, NEG cut before the boundary
    do_reset();
    set_cfg(1, 10, 30, 3, 50, 1'b1, 1'b1);
    start_run("trunc");
    for (int p = 0; p < 2; p++) begin
      measure(100, -1, 0, 0, len, nm, nn, nb, nz, nx);
      chk("trunc_len", len, 30);
      chk("trunc_main", nm, 10);
      chk("trunc_neg", nn, 16);
      chk("trunc_byp", nb, 1);
      chk("trunc_overlap", nx, 0);
    end

    // Invalid mode (two selects high) never starts
    do_reset();
    set_cfg(1, 10, 30, 0, 0, 1'b0, 1'b0);
    Start2 = 1'b1;
    power_Start = 1'b1;
    step(4);
    chk("badmode_running", running, 0);
    chk("badmode_main", gate_main, 0);

    // Ton=Ts set mid-period: current period unaffected, then IDLE + fault
    do_reset();
    set_cfg(3, 50, 750, 2, 100, 1'b1, 1'b1);
    start_run("flt");
    measure(1000, 200, 750, 750, len, nm, nn, nb, nz, nx);
    chk("flt_len", len, 750);
    chk("flt_main", nm, 50);
    chk("flt_running", running, 0);
    chk("flt_fault", fault, 1);
    chk("flt_main_off", gate_main, 0);
    chk("flt_byp_off", gate_bypass, 0);
    step(3);
    chk("flt_sticky", fault, 1);
    Ton = CNT_W'(50);
    step();
    chk("flt_clear", fault, 0);
    chk("flt_restart", running, 1);
    step();
    chk("flt_main_on", gate_main, 1);
    // Drop power mid-ON
    step(5);
    chk("pwr_main_pre", gate_main, 1);
    power_Start = 1'b0;
    step();
    chk("pwr_main", gate_main, 0);
    chk("pwr_running", running, 0);
    chk("pwr_fault", fault, 0);

    // Reset mid-NEG
    do_reset();
    set_cfg(3, 50, 750, 2, 100, 1'b1, 1'b1);
    start_run("rneg");
    step(60);
    chk("rneg_neg_pre", gate_neg, 1);
    rst = 1'b1;
    step();
    chk("rneg_neg", gate_neg, 0);
    chk("rneg_main", gate_main, 0);
    chk("rneg_byp", gate_bypass, 0);
    chk("rneg_running", running, 0);
    chk("rneg_tick", period_tick, 0);
    chk("rneg_fault", fault, 0);
    rst = 1'b0;

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time in case a period never ends.
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_timing_gen.md
PULSE_TIMING_GEN -- requirements
Module: pulse_timing_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period/phase counters.
REQ-002 SHALL have port clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port power_Start  input  1  run enable; pulses are generated only while it is high.
REQ-005 SHALL have ports Start1..Start4  input  1 each  cut-mode select; exactly one high is valid.
REQ-006 SHALL have ports panglu_en, Vneg_en  input  1 each  bypass-switch enable and negative-pulse enable.
REQ-007 SHALL have ports Ton, Ts, Dt  input  CNT_W each  on-time, period and dead-time in clk counts.
REQ-008 SHALL have port T_neg  input  8  negative-pulse width in clk counts.
REQ-009 SHALL have ports gate_main, gate_neg, gate_bypass  output  1 each  registered switch drives.
REQ-010 SHALL have ports running and period_tick  output  1 each  running: not IDLE; period_tick: one-cycle pulse on the last cycle of each period.
REQ-011 SHALL have port fault  output  1  sticky flag: invalid parameters were seen at a period boundary.

Function
REQ-012 SHALL implement states IDLE, ON, DEAD, NEG, OFF, plus a free-running period counter cnt that counts 0..Ts_l-1 while not IDLE.
REQ-013 SHALL capture Ton, Ts, Dt, T_neg, panglu_en, Vneg_en and the mode into shadow registers (_l) only on IDLE exit and at each period boundary (cnt==Ts_l-1); mid-period input changes have no effect.
REQ-014 SHALL treat parameters as valid when power_Start=1, the mode is one-hot, Ts>=2 and Ton<Ts.
REQ-015 IDLE -> ON when valid is sampled at edge k; gate_main SHALL first be high after edge k+1 and cnt=0 in that cycle.
REQ-016 ON SHALL last Ton_l cycles with gate_main=1; Ton_l==0 skips ON and the period starts in DEAD.
REQ-017 DEAD SHALL last Dt_l cycles with all gates 0; Dt_l==0 skips DEAD.
REQ-018 NEG SHALL be entered only when Vneg_l=1 and T_neg_l!=0; it lasts T_neg_l cycles with gate_neg=1.
REQ-019 OFF SHALL hold until cnt==Ts_l-1; gate_bypass SHALL equal panglu_l in OFF and be 0 in every other state.
REQ-020 At cnt==Ts_l-1: period_tick=1, cnt wraps to 0, shadows reload, and the next state is ON (or DEAD if the new Ton_l==0); if the reloaded parameters are invalid, the next state is IDLE and fault is set unless power_Start=0.
REQ-021 The period end SHALL override every phase: if Ton_l+Dt_l+T_neg_l >= Ts_l, later phases are truncated and the period length stays exactly Ts_l.
REQ-022 gate_main and gate_neg SHALL never both be 1; any transition between them SHALL pass through at least one cycle with both low, even when Dt_l==0.
REQ-023 power_Start low, sampled in any state, SHALL force IDLE with all gates 0 after the next edge; no period completion is required.
REQ-024 A mode change mid-period SHALL take effect only at the next boundary.
REQ-025 fault SHALL clear only on rst or on an IDLE -> ON transition.

Reset
REQ-026 While rst=1 sampled, the block SHALL enter IDLE with cnt=0, all shadows 0, and gate_main=gate_neg=gate_bypass=running=period_tick=fault=0; rst SHALL take priority over all other inputs, including mid-pulse.

Verification
REQ-027 Mode1: Ton=2500, Ts=22500, Dt=46, Vneg_en=0, power_Start 0->1 -> gate_main high for 2500 cycles starting 2 edges later, period 22500, period_tick every 22500 cycles.
REQ-028 Mode3: Ton=50, Ts=750, Dt=2, Vneg_en=1, T_neg=100, panglu_en=1 -> per period: 50 main, 2 dead, 100 neg, 598 bypass; gates never overlap.
REQ-029 Mode2: Ton=0, Ts=3000 -> gate_main stays 0, period_tick period 3000, bypass asserted in OFF when panglu_en=1.
REQ-030 Change Ton 2500->1000 at cnt=100 -> the current pulse stays 2500; the next period shows 1000.
REQ-031 Set Ton=Ts=750 at a boundary -> IDLE, fault=1, gates 0; drop power_Start mid-ON -> all gates 0 after one edge.
REQ-032 Assert rst mid-NEG -> gate_neg 0 and all outputs at reset values after the next edge.
